// File: rtl/raster_scan_ctrl_if.sv
// Shared pixel/triangle types and the triangle-in / pixel-out bundle for raster_scan_ctrl.
// slave is the scheduler's view; master is the producer/consumer side around it.
package raster_pkg;
    typedef struct packed {
        logic [15:0] tri_id;
        logic [31:0] attr;
    } triangle_state_t;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        triangle_state_t    triangle;
    } pixel_state_t;
endpackage

interface raster_scan_if;
    import raster_pkg::*;

    triangle_state_t    in_triangle;
    logic signed [15:0] in_bbox_x_min;
    logic signed [15:0] in_bbox_x_max;
    logic signed [15:0] in_bbox_y_min;
    logic signed [15:0] in_bbox_y_max;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    pixel_state_t       out_pixel;
    logic               out_valid;
    logic               out_ready;
    logic               eval_busy;
    logic               busy;
    logic               frame_done;
    logic [31:0]        pix_count;

    modport slave (
        input  in_triangle, in_bbox_x_min, in_bbox_x_max, in_bbox_y_min, in_bbox_y_max,
        input  in_last, in_valid, out_ready, eval_busy,
        output in_ready, out_pixel, out_valid, busy, frame_done, pix_count
    );

    modport master (
        output in_triangle, in_bbox_x_min, in_bbox_x_max, in_bbox_y_min, in_bbox_y_max,
        output in_last, in_valid, out_ready, eval_busy,
        input  in_ready, out_pixel, out_valid, busy, frame_done, pix_count
    );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Per-triangle raster scheduler: clips the bbox to the screen, walks it in raster order (first pixel
// 1 cycle after accept, pixel held while out_ready low), then waits for pixel_eval to drain at frame end.
module raster_scan_ctrl
    import raster_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic          clk,
    input  logic          rst,
    raster_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic signed [15:0] X_LIM = 16'(WIDTH - 1);
    localparam logic signed [15:0] Y_LIM = 16'(HEIGHT - 1);

    state_t             state_q, state_d;
    pixel_state_t       pix_q, pix_d;
    logic signed [15:0] cx_min_q, cx_min_d;
    logic signed [15:0] cx_max_q, cx_max_d;
    logic signed [15:0] cy_max_q, cy_max_d;
    logic               last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               drain_first_q, drain_first_d;
    logic [31:0]        pix_count_q, pix_count_d;

    logic signed [15:0] clip_x_min, clip_x_max, clip_y_min, clip_y_max;
    logic               clip_empty;

    always_comb begin
        clip_x_min = (bus.in_bbox_x_min < 16'sd0) ? 16'sd0 : bus.in_bbox_x_min;
        clip_x_max = (bus.in_bbox_x_max > X_LIM)  ? X_LIM  : bus.in_bbox_x_max;
        clip_y_min = (bus.in_bbox_y_min < 16'sd0) ? 16'sd0 : bus.in_bbox_y_min;
        clip_y_max = (bus.in_bbox_y_max > Y_LIM)  ? Y_LIM  : bus.in_bbox_y_max;
        clip_empty = (clip_x_min > clip_x_max) || (clip_y_min > clip_y_max);
    end

    always_comb begin
        state_d       = state_q;
        pix_d         = pix_q;
        cx_min_d      = cx_min_q;
        cx_max_d      = cx_max_q;
        cy_max_d      = cy_max_q;
        last_d        = last_q;
        out_valid_d   = out_valid_q;
        frame_done_d  = 1'b0;
        drain_first_d = drain_first_q;
        pix_count_d   = pix_count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cx_min_d = clip_x_min;
                    cx_max_d = clip_x_max;
                    cy_max_d = clip_y_max;
                    last_d   = bus.in_last;
                    if (clip_empty) begin
                        // Off-screen clip values never reach out_pixel, keeping it on-screen.
                        if (bus.in_last) begin
                            state_d       = DRAIN;
                            drain_first_d = 1'b1;
                        end
                    end else begin
                        pix_d.x        = clip_x_min;
                        pix_d.y        = clip_y_min;
                        pix_d.triangle = bus.in_triangle;
                        out_valid_d    = 1'b1;
                        state_d        = SCAN;
                    end
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pix_count_d = pix_count_q + 32'd1;
                    if (pix_q.x < cx_max_q) begin
                        pix_d.x = pix_q.x + 16'sd1;
                    end else if (pix_q.y < cy_max_q) begin
                        pix_d.x = cx_min_q;
                        pix_d.y = pix_q.y + 16'sd1;
                    end else begin
                        out_valid_d   = 1'b0;
                        state_d       = last_q ? DRAIN : IDLE;
                        drain_first_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The first DRAIN cycle is skipped so the final pixel is already inside pixel_eval.
                if (drain_first_q) begin
                    drain_first_d = 1'b0;
                end else if (!bus.eval_busy) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pix_q         <= '0;
            cx_min_q      <= '0;
            cx_max_q      <= '0;
            cy_max_q      <= '0;
            last_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            drain_first_q <= 1'b0;
            pix_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            cx_min_q      <= cx_min_d;
            cx_max_q      <= cx_max_d;
            cy_max_q      <= cy_max_d;
            last_q        <= last_d;
            out_valid_q   <= out_valid_d;
            frame_done_q  <= frame_done_d;
            drain_first_q <= drain_first_d;
            pix_count_q   <= pix_count_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_pixel  = pix_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pix_count  = pix_count_q;
endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: bbox vector table plus hand-written drain, stall and reset sequences,
// with expected pixels queued at drive time and popped on each output handshake.
module tb_raster_scan_ctrl;
    import raster_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    raster_scan_if bus();

    raster_scan_ctrl #(.WIDTH(320), .HEIGHT(240)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int x0, x1, y0, y1;
        bit last;
        int ex0, ex1, ey0, ey1;
        int exp_cyc;
    } vec_t;

    vec_t         vt[5];
    int           tests = 0;
    int           fails = 0;
    pixel_state_t sb[$];
    int           hs_count = 0;
    bit           stall_mode = 1'b0;
    bit [3:0]     pat = 4'b1001;
    int           pcyc = 0;
    logic         held_vld = 1'b0;
    pixel_state_t held_pix;
    int           exp_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (stall_mode) begin
            bus.out_ready = pat[pcyc % 4];
            pcyc++;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        pixel_state_t e;
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                chk("stall_hold_valid", 128'(bus.out_valid), 128'(1'b1));
                chk("stall_hold_pixel", 128'(bus.out_pixel), 128'(held_pix));
            end
            held_vld = bus.out_valid && !bus.out_ready;
            held_pix = bus.out_pixel;
            if (bus.out_valid && bus.out_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pixel: got %0h expected none", bus.out_pixel);
                end else begin
                    e = sb.pop_front();
                    chk("pixel", 128'(bus.out_pixel), 128'(e));
                end
            end
        end
    end

    task automatic send(input int x0, input int x1, input int y0, input int y1, input bit last,
                        input int ex0, input int ex1, input int ey0, input int ey1);
        triangle_state_t t;
        pixel_state_t    p;
        @(posedge clk);
        #1;
        t.tri_id = 16'($urandom);
        t.attr   = $urandom;
        bus.in_triangle   = t;
        bus.in_bbox_x_min = 16'(x0);
        bus.in_bbox_x_max = 16'(x1);
        bus.in_bbox_y_min = 16'(y0);
        bus.in_bbox_y_max = 16'(y1);
        bus.in_last       = last;
        bus.in_valid      = 1'b1;
        for (int y = ey0; y <= ey1; y++) begin
            for (int x = ex0; x <= ex1; x++) begin
                p.x = 16'(x);
                p.y = 16'(y);
                p.triangle = t;
                sb.push_back(p);
            end
        end
        if (ex1 >= ex0 && ey1 >= ey0) exp_total += (ex1 - ex0 + 1) * (ey1 - ey0 + 1);
        @(posedge clk);
        #1;
        bus.in_valid      = 1'b0;
        bus.in_triangle   = {16'($urandom), 32'($urandom)};
        bus.in_bbox_x_min = 16'($urandom);
        bus.in_bbox_x_max = 16'($urandom);
        bus.in_last       = ~last;
    endtask

    // Called at a negedge; counts negedges until in_ready is seen high.
    task automatic wait_ready(input int start, output int cyc);
        cyc = start;
        while (!bus.in_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc, pulses, first, base_hs, n;

        vt[0] = '{2, 4, 3, 4, 1'b0, 2, 4, 3, 4, 7};
        vt[1] = '{-5, 1, -2, 0, 1'b0, 0, 1, 0, 0, 3};
        vt[2] = '{319, 325, 239, 250, 1'b0, 319, 319, 239, 239, 2};
        vt[3] = '{-20, -1, 5, 6, 1'b0, 0, -1, 5, 6, 1};
        vt[4] = '{10, 12, 100, 100, 1'b0, 10, 12, 100, 100, 4};

        bus.in_triangle   = '0;
        bus.in_bbox_x_min = '0;
        bus.in_bbox_x_max = '0;
        bus.in_bbox_y_min = '0;
        bus.in_bbox_y_max = '0;
        bus.in_last       = 1'b0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b1;
        bus.eval_busy     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_frame_done", 128'(bus.frame_done), 128'(0));
        chk("rst_pix_count", 128'(bus.pix_count), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_out_pixel", 128'(bus.out_pixel), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send(vt[i].x0, vt[i].x1, vt[i].y0, vt[i].y1, vt[i].last,
                 vt[i].ex0, vt[i].ex1, vt[i].ey0, vt[i].ey1);
            @(negedge clk);
            chk($sformatf("vec%0d_first_valid", i), 128'(bus.out_valid),
                128'(vt[i].ex1 >= vt[i].ex0 && vt[i].ey1 >= vt[i].ey0));
            wait_ready(1, cyc);
            chk($sformatf("vec%0d_cycles_to_ready", i), 128'(cyc), 128'(vt[i].exp_cyc));
            chk($sformatf("vec%0d_sb_empty", i), 128'(sb.size()), 128'(0));
            chk($sformatf("vec%0d_pix_count", i), 128'(bus.pix_count), 128'(exp_total));
        end

        // Empty off-screen box closing the frame.
        send(400, 410, 10, 12, 1'b1, 1, 0, 1, 0);
        @(negedge clk);
        chk("drain_busy", 128'(bus.busy), 128'(1));
        chk("drain_in_ready", 128'(bus.in_ready), 128'(0));
        pulses = 0;
        first  = 0;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("empty_last_pulses", 128'(pulses), 128'(1));
        chk("empty_last_within_2", 128'(first >= 2 && first <= 3), 128'(1));
        chk("empty_last_idle", 128'(bus.in_ready), 128'(1));

        // Stalled 2x2 triangle.
        base_hs    = hs_count;
        pcyc       = 0;
        stall_mode = 1'b1;
        send(0, 1, 0, 1, 1'b0, 0, 1, 0, 1);
        @(negedge clk);
        wait_ready(1, cyc);
        chk("stall_done", 128'(cyc < 2000), 128'(1));
        chk("stall_handshakes", 128'(hs_count - base_hs), 128'(4));
        chk("stall_sb_empty", 128'(sb.size()), 128'(0));
        chk("stall_pix_count", 128'(bus.pix_count), 128'(exp_total));
        stall_mode = 1'b0;
        @(negedge clk);

        // Single pixel, last, evaluator busy for a while after the handshake.
        bus.eval_busy = 1'b1;
        send(5, 5, 7, 7, 1'b1, 5, 5, 7, 7);
        pulses = 0;
        repeat (11) begin
            @(negedge clk);
            if (bus.frame_done) pulses++;
            chk("busy_hold_in_ready", 128'(bus.in_ready), 128'(0));
        end
        chk("busy_hold_no_pulse", 128'(pulses), 128'(0));
        chk("single_sb_empty", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
        bus.eval_busy = 1'b0;
        @(negedge clk);
        chk("drain_not_early", 128'(bus.frame_done), 128'(0));
        @(negedge clk);
        chk("drain_pulse", 128'(bus.frame_done), 128'(1));
        chk("drain_idle", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        chk("drain_pulse_once", 128'(bus.frame_done), 128'(0));

        // Reset in the middle of a 3x3 scan.
        base_hs = hs_count;
        send(0, 2, 0, 2, 1'b0, 0, 2, 0, 2);
        n = 0;
        while (hs_count < base_hs + 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("mid_scan_reached", 128'(n < 50), 128'(1));
        #1;
        chk("mid_scan_pix_count", 128'(bus.pix_count), 128'(exp_total - 6));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        exp_total = 0;
        chk("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_mid_busy", 128'(bus.busy), 128'(0));
        chk("rst_mid_pix_count", 128'(bus.pix_count), 128'(0));
        chk("rst_mid_in_ready", 128'(bus.in_ready), 128'(1));
        rst = 1'b0;
        send(3, 4, 5, 5, 1'b0, 3, 4, 5, 5);
        @(negedge clk);
        chk("post_rst_first_valid", 128'(bus.out_valid), 128'(1));
        wait_ready(1, cyc);
        chk("post_rst_cycles", 128'(cyc), 128'(3));
        chk("post_rst_sb_empty", 128'(sb.size()), 128'(0));
        chk("post_rst_pix_count", 128'(bus.pix_count), 128'(2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
